// File: rtl/tkz_pkg.sv
// Shared types and helpers for the masked TKz state store.
package tkz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } fsm_e;

  // Per-share next-state selection, decoded once in the top and broadcast.
  typedef enum logic [2:0] {
    SEL_HOLD    = 3'd0,
    SEL_SHIFT   = 3'd1,
    SEL_UPD     = 3'd2,
    SEL_REV     = 3'd3,
    SEL_RESTORE = 3'd4
  } sel_e;

  function automatic int state_w(input int words, input int w);
    return words * w;
  endfunction

  // Beat-counter width; a single-word load still needs one counter bit.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/tkz_share_reg.sv
// One Boolean share of the TKz state: state and snapshot registers with the
// load-shift / capture / restore mux. Shares never see each other's data.
module tkz_share_reg
  import tkz_pkg::*;
#(
  parameter int W          = 32,
  parameter int WORDS      = 4,
  parameter int CLOCK_GATE = 0,
  localparam int STATE_W   = state_w(WORDS, W)
) (
  input  logic               clk,
  input  logic               rst,
  input  sel_e               sel,
  input  logic               snap_en,
  input  logic [W-1:0]       si_word,
  input  logic [STATE_W-1:0] upd_state,
  input  logic [STATE_W-1:0] rev_state,
  output logic [STATE_W-1:0] state_q
);

  logic [STATE_W-1:0] snap_q;
  logic [STATE_W-1:0] state_d;
  logic               state_en;
  logic               gclk;

  assign state_en = (sel != SEL_HOLD);

  // Next-state mux: new load words enter at the top so the first word ends in word 0.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (sel)
      SEL_SHIFT:   state_d = {si_word, state_q[STATE_W-1:W]};
      SEL_UPD:     state_d = upd_state;
      SEL_REV:     state_d = rev_state;
      SEL_RESTORE: state_d = snap_q;
      default:     state_d = state_q;
    endcase
  end

  if (CLOCK_GATE != 0) begin : g_cg
    logic en_l;
    // Glitch-free clock gate: enable is sampled while the clock is low.
    always_latch begin
      // NOTE: this latch is intentional; it is the standard clock-gating cell.
      if (!clk) en_l = state_en | snap_en;
    end
    assign gclk = clk & en_l;
  end else begin : g_nocg
    assign gclk = clk;
  end

  // State and snapshot registers; snapshot takes the pre-update state, so snap+restore swaps.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      // NOTE: the snapshot is reset too, so a restore before any snap yields a defined zero state.
      state_q <= '0;
      snap_q  <= '0;
    end else begin
      // NOTE: non-blocking so snap_q captures the old state_q even when both update together.
      if (state_en) state_q <= state_d;
      if (snap_en)  snap_q  <= state_q;
    end
  end

endmodule

// File: rtl/tkz_update_nshare.sv
// Masked TKz state store: load FSM, beat counter and handshake, with the
// capture/snapshot decode broadcast to NSHARES lock-step share registers.
module tkz_update_nshare
  import tkz_pkg::*;
#(
  parameter int NSHARES    = 4,
  parameter int W          = 32,
  parameter int WORDS      = 4,
  parameter int CLOCK_GATE = 0,
  localparam int STATE_W   = state_w(WORDS, W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_load,
  input  logic [NSHARES*W-1:0]       si_data,
  input  logic                       si_valid,
  output logic                       si_ready,
  output logic                       load_done,
  input  logic                       upd,
  input  logic                       rev,
  input  logic                       snap,
  input  logic                       restore,
  input  logic [NSHARES*STATE_W-1:0] skinny_tkz,
  input  logic [NSHARES*STATE_W-1:0] skinny_tkz_revert,
  output logic [NSHARES*W-1:0]       tkz,
  output logic [NSHARES*STATE_W-1:0] tkz_full
);

  localparam int CNT_W = cnt_w(WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS - 1);

  fsm_e             fsm_q;
  logic [CNT_W-1:0] cnt_q;
  sel_e             sel;
  logic             snap_en;
  logic             beat;

  assign si_ready = (fsm_q == LOAD);
  assign beat     = si_valid & si_ready;

  // Decode the share-register operation; load path wins, captures only in READY.
  always_comb begin
    sel     = SEL_HOLD;
    snap_en = 1'b0;
    if (fsm_q == LOAD) begin
      if (beat) sel = SEL_SHIFT;
    end else if (fsm_q == READY) begin
      if (rev)          sel = SEL_REV;
      else if (upd)     sel = SEL_UPD;
      else if (restore) sel = SEL_RESTORE;
      snap_en = snap;
    end
  end

  // Load FSM and beat counter; a start_load during LOAD restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      cnt_q     <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start_load) begin
            fsm_q <= LOAD;
            cnt_q <= '0;
          end
        end
        LOAD: begin
          if (start_load) begin
            // A beat in the restart cycle becomes beat 0 of the new load.
            cnt_q <= beat ? CNT_W'(1) : '0;
          end else if (beat) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q     <= '0;
              fsm_q     <= READY;
              load_done <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        READY: begin
          if (start_load) begin
            fsm_q <= LOAD;
            cnt_q <= '0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    logic [STATE_W-1:0] share_state;

    tkz_share_reg #(
      .W          (W),
      .WORDS      (WORDS),
      .CLOCK_GATE (CLOCK_GATE)
    ) u_share (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .snap_en   (snap_en),
      .si_word   (si_data[s*W +: W]),
      .upd_state (skinny_tkz[s*STATE_W +: STATE_W]),
      .rev_state (skinny_tkz_revert[s*STATE_W +: STATE_W]),
      .state_q   (share_state)
    );

    assign tkz_full[s*STATE_W +: STATE_W] = share_state;
    assign tkz[s*W +: W]                  = share_state[W-1:0];
  end

endmodule

// File: tb/tb_tkz_update_nshare.sv
// Directed plus random bench for tkz_update_nshare: a 4x128b instance and a
// pair of 2x64b instances (ungated and clock-gated) checked against a model.
module tb_tkz_update_nshare;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_load, si_valid, upd, rev, snap, restore;
  logic [127:0] si_data;
  logic [511:0] skinny, skinny_rev;

  logic         si_ready0, load_done0;
  logic [127:0] tkz0;
  logic [511:0] full0;

  logic         si_ready_a, load_done_a, si_ready_b, load_done_b;
  logic [63:0]  tkz_a, tkz_b;
  logic [127:0] full_a, full_b;
  logic [127:0] skinny_s, skinny_rev_s;

  assign skinny_s     = {skinny[128 +: 64], skinny[0 +: 64]};
  assign skinny_rev_s = {skinny_rev[128 +: 64], skinny_rev[0 +: 64]};

  always #5 clk = ~clk;

  tkz_update_nshare #(.NSHARES(4), .W(32), .WORDS(4), .CLOCK_GATE(0)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .si_data(si_data),
    .si_valid(si_valid), .si_ready(si_ready0), .load_done(load_done0),
    .upd(upd), .rev(rev), .snap(snap), .restore(restore),
    .skinny_tkz(skinny), .skinny_tkz_revert(skinny_rev),
    .tkz(tkz0), .tkz_full(full0)
  );

  tkz_update_nshare #(.NSHARES(2), .W(32), .WORDS(2), .CLOCK_GATE(0)) dut_a (
    .clk(clk), .rst(rst), .start_load(start_load), .si_data(si_data[63:0]),
    .si_valid(si_valid), .si_ready(si_ready_a), .load_done(load_done_a),
    .upd(upd), .rev(rev), .snap(snap), .restore(restore),
    .skinny_tkz(skinny_s), .skinny_tkz_revert(skinny_rev_s),
    .tkz(tkz_a), .tkz_full(full_a)
  );

  tkz_update_nshare #(.NSHARES(2), .W(32), .WORDS(2), .CLOCK_GATE(1)) dut_b (
    .clk(clk), .rst(rst), .start_load(start_load), .si_data(si_data[63:0]),
    .si_valid(si_valid), .si_ready(si_ready_b), .load_done(load_done_b),
    .upd(upd), .rev(rev), .snap(snap), .restore(restore),
    .skinny_tkz(skinny_s), .skinny_tkz_revert(skinny_rev_s),
    .tkz(tkz_b), .tkz_full(full_b)
  );

  // Reference model: index 0 = 4 shares x 4 words, index 1 = 2 shares x 2 words.
  // fsm encoding: 0 idle, 1 load, 2 ready.
  int           m_fsm  [2];
  int           m_cnt  [2];
  logic         m_done [2];
  logic [127:0] m_st   [2][4];
  logic [127:0] m_sn   [2][4];

  typedef struct {
    string        tag;
    logic [511:0] full0;
    logic [127:0] tkz0;
    logic         rdy0, done0;
    logic [127:0] full1;
    logic [63:0]  tkz1;
    logic         rdy1, done1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fsm[i]  = 0;
      m_cnt[i]  = 0;
      m_done[i] = 1'b0;
      for (int s = 0; s < 4; s++) begin
        m_st[i][s] = '0;
        m_sn[i][s] = '0;
      end
    end
  endtask

  task automatic model_edge(input int i, input int ns, input int words);
    int           statew;
    logic [127:0] mask, old;
    logic         beat;
    statew    = words * 32;
    mask      = (statew == 128) ? {128{1'b1}} : ((128'd1 << statew) - 128'd1);
    beat      = (m_fsm[i] == 1) && si_valid;
    m_done[i] = 1'b0;
    for (int s = 0; s < ns; s++) begin
      if (beat) begin
        m_st[i][s] = ((m_st[i][s] >> 32) | ({96'd0, si_data[s*32 +: 32]} << (statew - 32))) & mask;
      end else if (m_fsm[i] == 2) begin
        old = m_st[i][s];
        if (rev)          m_st[i][s] = skinny_rev[s*128 +: 128] & mask;
        else if (upd)     m_st[i][s] = skinny[s*128 +: 128] & mask;
        else if (restore) m_st[i][s] = m_sn[i][s];
        if (snap)         m_sn[i][s] = old;
      end
    end
    case (m_fsm[i])
      0: if (start_load) begin m_fsm[i] = 1; m_cnt[i] = 0; end
      1: begin
        if (start_load) m_cnt[i] = beat ? 1 : 0;
        else if (beat) begin
          if (m_cnt[i] == words - 1) begin
            m_cnt[i] = 0; m_fsm[i] = 2; m_done[i] = 1'b1;
          end else m_cnt[i]++;
        end
      end
      default: if (start_load) begin m_fsm[i] = 1; m_cnt[i] = 0; end
    endcase
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] model_full0();
    logic [511:0] f;
    for (int s = 0; s < 4; s++) f[s*128 +: 128] = m_st[0][s];
    return f;
  endfunction

  // One clock: predict, push to scoreboard, let the edge happen, pop and compare.
  task automatic step(input string tag);
    exp_t e, got;
    model_edge(0, 4, 4);
    model_edge(1, 2, 2);
    e.tag   = tag;
    e.full0 = model_full0();
    for (int s = 0; s < 4; s++) e.tkz0[s*32 +: 32] = m_st[0][s][31:0];
    for (int s = 0; s < 2; s++) begin
      e.full1[s*64 +: 64] = m_st[1][s][63:0];
      e.tkz1[s*32 +: 32]  = m_st[1][s][31:0];
    end
    e.rdy0  = (m_fsm[0] == 1);
    e.done0 = m_done[0];
    e.rdy1  = (m_fsm[1] == 1);
    e.done1 = m_done[1];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, ".full0"}, full0, got.full0);
      chk({got.tag, ".tkz0"}, tkz0, got.tkz0);
      chk({got.tag, ".hs0"}, {si_ready0, load_done0}, {got.rdy0, got.done0});
      chk({got.tag, ".full_a"}, full_a, got.full1);
      chk({got.tag, ".tkz_a"}, tkz_a, got.tkz1);
      chk({got.tag, ".hs_a"}, {si_ready_a, load_done_a}, {got.rdy1, got.done1});
      chk({got.tag, ".full_b"}, full_b, got.full1);
      chk({got.tag, ".tkz_b"}, tkz_b, got.tkz1);
      chk({got.tag, ".hs_b"}, {si_ready_b, load_done_b}, {got.rdy1, got.done1});
    end
    start_load = 1'b0; si_valid = 1'b0;
    upd = 1'b0; rev = 1'b0; snap = 1'b0; restore = 1'b0;
  endtask

  task automatic load_word(input int k);
    logic [31:0] w0;
    w0 = 32'h11111111 * (k + 1);
    for (int s = 0; s < 4; s++) si_data[s*32 +: 32] = w0 ^ (32'h01010101 * s);
    si_valid = 1'b1;
  endtask

  logic [511:0] saved_l, saved_r;

  initial begin
    rst = 1'b1;
    start_load = 1'b0; si_valid = 1'b0;
    upd = 1'b0; rev = 1'b0; snap = 1'b0; restore = 1'b0;
    si_data = '0; skinny = '0; skinny_rev = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_full0", full0, '0);
    chk("rst_tkz0", tkz0, '0);
    chk("rst_hs0", {si_ready0, load_done0}, 2'b00);
    chk("rst_full_b", full_b, '0);

    // Captures in IDLE are ignored
    upd = 1'b1; rev = 1'b1; restore = 1'b1; snap = 1'b1;
    skinny = rand512(); skinny_rev = rand512();
    step("idle_upd");
    chk("idle_upd_state", full0, '0);

    // Reset in the middle of a load
    start_load = 1'b1; step("start0");
    si_valid = 1'b1; si_data = {$urandom, $urandom, $urandom, $urandom}; step("pre_b0");
    si_valid = 1'b1; si_data = {$urandom, $urandom, $urandom, $urandom}; step("pre_b1");
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_full0", full0, '0);
    chk("midrst_tkz0", tkz0, '0);
    chk("midrst_hs0", {si_ready0, load_done0}, 2'b00);
    chk("midrst_full_a", full_a, '0);
    rst = 1'b0;
    model_reset();

    // Full load with a 3-cycle gap after the first beat
    start_load = 1'b1; step("start1");
    load_word(0); step("beat0");
    for (int g = 0; g < 3; g++) begin
      si_data = {$urandom, $urandom, $urandom, $urandom};
      step("gap");
    end
    load_word(1); step("beat1");
    load_word(2); step("beat2");
    chk("pre_done", load_done0, 1'b0);
    load_word(3); step("beat3");
    chk("load_done_pulse", load_done0, 1'b1);
    chk("load_full_s0", full0[127:0], 128'h44444444_33333333_22222222_11111111);
    chk("load_tkz_s0", tkz0[31:0], 32'h11111111);
    step("post_load");
    chk("load_done_once", load_done0, 1'b0);
    saved_l = model_full0();

    // snap, upd with share1 = A5.., restore
    snap = 1'b1; step("snap");
    skinny = rand512(); skinny[128 +: 128] = {16{8'hA5}};
    upd = 1'b1; step("upd");
    chk("upd_s1_a5", full0[255:128], {16{8'hA5}});
    restore = 1'b1; step("restore");
    chk("restore_loaded", full0, saved_l);

    // rev wins over upd
    skinny = rand512(); skinny_rev = rand512();
    upd = 1'b1; rev = 1'b1; step("upd_rev");
    chk("rev_prio", full0, skinny_rev);
    saved_r = skinny_rev;

    // snap+restore swap: state=R, snapshot=L
    snap = 1'b1; restore = 1'b1; step("swap");
    chk("swap_state", full0, saved_l);
    restore = 1'b1; step("swap_back");
    chk("swap_snapshot", full0, saved_r);

    // Random traffic across all three instances
    for (int n = 0; n < 300; n++) begin
      start_load = ($urandom_range(0, 39) == 0);
      si_valid   = !start_load && ($urandom_range(0, 1) == 1);
      upd        = ($urandom_range(0, 3) == 0);
      rev        = ($urandom_range(0, 3) == 0);
      snap       = ($urandom_range(0, 3) == 0);
      restore    = ($urandom_range(0, 3) == 0);
      si_data    = {$urandom, $urandom, $urandom, $urandom};
      skinny     = rand512();
      skinny_rev = rand512();
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
